// File: rtl/bintobcd_seq.sv
// Signed 11-bit binary to 8-digit display code converter.
// Double-dabble core, one magnitude bit per clock, start/busy/done handshake.
module bintobcd_seq #(
    parameter logic [3:0] NEG_CODE   = 4'hE,
    parameter logic [3:0] BLANK_CODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [10:0] bin_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] bcd_out,
    output logic        overflow
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_FMT  = 2'd2;

    localparam logic [3:0]  LAST_BIT  = 4'd10;
    localparam logic [31:0] RESET_OUT = {{7{BLANK_CODE}}, 4'h0};

    logic [1:0]  state_q, state_d;
    logic        sign_q, sign_d;
    logic [10:0] mag_q, mag_d;
    logic [15:0] scr_q, scr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] bcd_q, bcd_d;
    logic        ovf_q, ovf_d;
    logic        done_q, done_d;

    function automatic logic [15:0] adjust(input logic [15:0] s);
        logic [15:0] r;
        r = s;
        for (int i = 0; i < 4; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Digits above the leading nonzero one are blanked; sign sits just left of it.
    function automatic logic [31:0] format(
        input logic [15:0] s,
        input logic        neg
    );
        logic [2:0]  msd;
        logic [4:0]  pos;
        logic [31:0] w;
        if (s[15:12] != 4'd0) begin
            msd = 3'd3;
        end else if (s[11:8] != 4'd0) begin
            msd = 3'd2;
        end else if (s[7:4] != 4'd0) begin
            msd = 3'd1;
        end else begin
            msd = 3'd0;
        end
        w = {8{BLANK_CODE}};
        for (int i = 0; i < 4; i++) begin
            if (3'(i) <= msd) begin
                w[4*i +: 4] = s[4*i +: 4];
            end
        end
        pos = {msd, 2'b00} + 5'd4;
        if (neg) begin
            w[pos +: 4] = NEG_CODE;
        end
        return w;
    endfunction

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        mag_d   = mag_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sign_d  = bin_in[10];
                    mag_d   = bin_in[10] ? (~bin_in + 11'd1) : bin_in;
                    scr_d   = 16'd0;
                    cnt_d   = 4'd0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                {scr_d, mag_d} = {adjust(scr_q), mag_q} << 1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_BIT) begin
                    state_d = S_FMT;
                end
            end
            S_FMT: begin
                bcd_d   = format(scr_q, sign_q);
                // A nonzero thousands digit means the magnitude exceeds 999.
                ovf_d   = (scr_q[15:12] != 4'd0);
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sign_q  <= 1'b0;
            mag_q   <= 11'd0;
            scr_q   <= 16'd0;
            cnt_q   <= 4'd0;
            bcd_q   <= RESET_OUT;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            mag_q   <= mag_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bintobcd_seq.sv
// Randomized self-checking bench for bintobcd_seq.
// Reference model formats digits with integer arithmetic.
module tb_bintobcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [10:0] bin_in;
    logic        busy;
    logic        done;
    logic [31:0] bcd_out;
    logic        overflow;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] last_exp;
    logic        last_ovf;

    bintobcd_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model(input int v);
        logic [31:0] w;
        int m;
        int nd;
        w  = 32'hFFFF_FFFF;
        m  = (v < 0) ? -v : v;
        nd = 0;
        do begin
            w[4*nd +: 4] = 4'(m % 10);
            m = m / 10;
            nd++;
        end while (m > 0);
        if (v < 0) w[4*nd +: 4] = 4'hE;
        return w;
    endfunction

    function automatic int decode(input logic [31:0] w);
        int acc;
        int p;
        bit neg;
        logic [3:0] nib;
        acc = 0;
        p   = 1;
        neg = 0;
        for (int i = 0; i < 8; i++) begin
            nib = w[4*i +: 4];
            if (nib <= 4'd9) begin
                acc = acc + int'(nib) * p;
                p   = p * 10;
            end else if (nib == 4'hE) begin
                neg = 1;
            end
        end
        return neg ? -acc : acc;
    endfunction

    task automatic run_conv(input int v, input bit poke);
        logic [31:0] e;
        logic        eo;
        int k;
        e  = model(v);
        eo = (v > 999) || (v < -999);
        start  = 1'b1;
        bin_in = 11'(v);
        tick();
        start  = 1'b0;
        bin_in = 11'($urandom);
        k = 0;
        while (!done && k < 30) begin
            chk("busy", {31'd0, busy}, 32'd1);
            chk("hold", bcd_out, last_exp);
            chk("hold_ovf", {31'd0, overflow}, {31'd0, last_ovf});
            if (poke && k == 5) begin
                start  = 1'b1;
                bin_in = 11'($urandom);
            end
            if (poke && k == 6) start = 1'b0;
            tick();
            k++;
        end
        chk("latency", 32'(k), 32'd12);
        chk("bcd", bcd_out, e);
        chk("ovf", {31'd0, overflow}, {31'd0, eo});
        chk("busy_done", {31'd0, busy}, 32'd0);
        last_exp = e;
        last_ovf = eo;
        tick();
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk("bcd_keep", bcd_out, e);
    endtask

    int fixed_vals[10] = '{123, -45, -7, -999, 1023, -1024, 5, 999, -1, 100};
    int seq_vals[3]    = '{12, 34, 56};

    initial begin
        int k;
        int nd;
        int v;
        rst    = 1'b1;
        start  = 1'b0;
        bin_in = 11'd0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        last_exp = 32'hFFFF_FFF0;
        last_ovf = 1'b0;
        chk("rst_bcd", bcd_out, 32'hFFFF_FFF0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);

        run_conv(0, 0);
        foreach (fixed_vals[i]) run_conv(fixed_vals[i], 0);
        run_conv(77, 1);
        run_conv(-600, 1);

        start  = 1'b1;
        bin_in = 11'(seq_vals[0]);
        for (int j = 0; j < 3; j++) begin
            tick();
            k = 0;
            while (!done && k < 30) begin
                if (k == 3 && j < 2) bin_in = 11'(seq_vals[j+1]);
                tick();
                k++;
            end
            chk("b2b_latency", 32'(k), 32'd12);
            chk("b2b_bcd", bcd_out, model(seq_vals[j]));
            if (j == 2) start = 1'b0;
        end
        last_exp = model(seq_vals[2]);
        last_ovf = 1'b0;
        tick();
        chk("b2b_idle", {31'd0, busy}, 32'd0);

        start  = 1'b1;
        bin_in = 11'(-321);
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_bcd", bcd_out, 32'hFFFF_FFF0);
        chk("mid_rst_ovf", {31'd0, overflow}, 32'd0);
        last_exp = 32'hFFFF_FFF0;
        last_ovf = 1'b0;
        nd = 0;
        repeat (20) begin
            tick();
            if (done) nd++;
        end
        chk("mid_rst_nodone", 32'(nd), 32'd0);
        run_conv(88, 0);

        repeat (200) begin
            v = int'($urandom_range(2047)) - 1024;
            run_conv(v, $urandom_range(1) == 1);
        end

        for (int x = -999; x <= 999; x++) begin
            run_conv(x, 0);
            chk("round_trip", 32'(decode(bcd_out)), 32'(x));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bintobcd_seq.md
Name: bintobcd_seq

Overview:
- Sequential signed-binary to display-BCD encoder; the inverse of the calculator's BCD-to-binary decoder.
- Takes an 11-bit two's-complement result and produces a 32-bit, 8-digit code word for the display path:
  - numeric digits 0-9;
  - NEG_CODE for the minus sign;
  - BLANK_CODE for unused digits.
- Uses a double-dabble shift/add-3 FSM, one magnitude bit per clock, with a start/busy/done handshake.

Parameters:
- NEG_CODE, 4'hE, digit code emitted for the minus sign.
- BLANK_CODE, 4'hF, digit code emitted for blank (leading/unused) digit positions.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request conversion of bin_in; sampled only in IDLE.
- bin_in  input  11  signed two's-complement value, range -1024..1023.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse; bcd_out and overflow are valid from this cycle on.
- bcd_out  output  32  8 digit codes; [3:0] is ones, [31:28] is digit 7.
- overflow  output  1  high when |bin_in| > 999, i.e. not representable by the 3-digit-plus-sign decoder.

Behaviour:
- Synchronous reset, active-high, overrides everything including mid-conversion:
  - FSM goes to IDLE; busy=0, done=0, overflow=0;
  - bcd_out=32'hFFFF_FFF0 (displays "0" with default codes);
  - internal shift/BCD registers cleared; any partial result is discarded and never output.
- States: IDLE, CONVERT, FORMAT.
- IDLE:
  - on start=1, capture sign = bin_in[10] and mag = |bin_in| as unsigned 11 bits (-1024 -> 11'd1024);
  - clear the 16-bit BCD scratch and the bit counter; go to CONVERT; busy=1 from the next cycle.
- CONVERT, exactly 11 cycles, one per cycle:
  - add 3 to every 4-bit scratch nibble >= 5;
  - then shift {scratch, mag} left by 1;
  - after the 11th cycle go to FORMAT.
- FORMAT, 1 cycle: build bcd_out from the scratch digits D3..D0 (thousands..ones).
  - Leading-zero digits above the most significant nonzero digit become BLANK_CODE; D0 is always numeric, so 0 gives "0".
  - If sign=1, NEG_CODE goes in the digit immediately left of the most significant numeric digit.
  - All remaining digits up to 7 are BLANK_CODE.
  - overflow = (mag > 999).
  - Register bcd_out and overflow, pulse done=1, drop busy, return to IDLE.
- Latency: start sampled at edge N → done high in the cycle after edge N+12, i.e. 13 cycles of work.
- The done cycle is an IDLE cycle: a start seen then is accepted, giving back-to-back throughput of one result per 13 cycles.
- start while busy=1 is ignored; no queueing.
- bcd_out and overflow hold their last value until the next done; they never show intermediate values.
- bin_in is only sampled on the accepting edge; later changes have no effect.
- Digit positions 5-7 are always BLANK_CODE. Position 4 is used only for NEG_CODE at -1000..-1024.

Test Plan:
- After rst, with no start → bcd_out=32'hFFFF_FFF0, busy=0, done=0, overflow=0.
- start with bin_in=0 → done exactly 13 cycles later; bcd_out=32'hFFFF_FFF0; busy high for the preceding 12 cycles.
- Signed formatting checks:
  - bin_in=123 → 32'hFFFF_F123;
  - -45 → 32'hFFFF_FE45;
  - -7 → 32'hFFFF_FFE7;
  - -999 → 32'hFFFF_E999;
  - overflow=0 for all of these.
- Range-edge checks:
  - bin_in=1023 → 32'hFFFF_1023, overflow=1;
  - -1024 → 32'hFFFE_1024, overflow=1;
  - next conversion of 5 → 32'hFFFF_FFF5, overflow=0.
- Handshake checks:
  - start=1 held continuously with bin_in switching 12 → 34 → 56 mid-conversion: only values sampled on done cycles are converted, and done pulses every 13 cycles;
  - a start pulse during busy is ignored.
- Reset mid-operation: rst at cycle 6 of converting -321 → next cycle busy=0, no done pulse, bcd_out=32'hFFFF_FFF0; a fresh start of 88 then yields 32'hFFFF_FF88.
- Round trip: every value -999..999 passed through this block then the BCD-to-binary decoder returns the original value.
